reduce_nway_pipe: RTL



---
 rtl/reduce_pkg.sv | 36 +++
 rtl/reduce_stage.sv | 69 ++++++
 rtl/reduce_nway_pipe.sv | 85 ++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// -----------------------------------------------------------------------------
// reduce_pkg
// Shared definitions for the pipelined N-input bit-reduction unit:
//   - 2-bit reduction mode encodings
//   - ident()  : identity bit of a mode, used to pad the input word
//   - clog2()  : ceiling log2, elaboration-time helper
//   - lat_of() : pipeline depth (number of tree levels) for a given width
// -----------------------------------------------------------------------------
package reduce_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  // Pad bits must not disturb the result: AND needs 1s, every other mode 0s
  // (NOR is an OR inside the tree, inverted only at the very end).
  function automatic logic ident(input logic [1:0] mode);
    return (mode == MODE_AND);
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single-bit input still gets one register stage.
  function automatic int lat_of(input int w);
    return (clog2(w) < 1) ? 1 : clog2(w);
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// -----------------------------------------------------------------------------
// reduce_stage
// One level of the reduction tree: combines adjacent bit pairs of data_i with
// the mode operator and registers the IN_W/2-bit result together with the
// transaction's valid bit and mode. Advances only when en_i is high.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low clear of all registers
//   en_i     global advance enable (hold when low)
//   valid_i  transaction valid entering this level
//   mode_i   reduction mode of the entering transaction
//   data_i   IN_W bits from the previous level
//   valid_o  registered valid
//   mode_o   registered mode
//   data_o   registered IN_W/2 reduced bits
// -----------------------------------------------------------------------------
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                valid_i,
  input  logic [1:0]          mode_i,
  input  logic [IN_W-1:0]     data_i,
  output logic                valid_o,
  output logic [1:0]          mode_o,
  output logic [IN_W/2-1:0]   data_o
);

  localparam int OUT_W = IN_W / 2;

  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic [1:0]       mode_q;

  // NOR shares the OR tree; its inversion happens once at the top level.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (mode_i)
        MODE_AND: data_d[i] = data_i[2*i] & data_i[2*i+1];
        MODE_XOR: data_d[i] = data_i[2*i] ^ data_i[2*i+1];
        default:  data_d[i] = data_i[2*i] | data_i[2*i+1];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_OR;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reduce_nway_pipe.sv
// -----------------------------------------------------------------------------
// reduce_nway_pipe
// Pipelined WIDTH-input bit reduction (OR / AND / XOR / NOR selected per
// transaction). The word is padded to a power of two with the mode's identity
// bit and reduced by a balanced binary tree with one register stage per level,
// so latency is LAT = max(1, ceil(log2(WIDTH))) cycles. A single global stall
// (en = out_ready | ~out_valid) freezes every stage while the output is held.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, flushes all in-flight words
//   in_valid   in_data/in_mode valid
//   in_ready   unit accepts the input this cycle (0 while in reset)
//   in_data    WIDTH-bit word to reduce
//   in_mode    00 OR, 01 AND, 10 XOR, 11 NOR
//   out_valid  out_bit/out_mode valid
//   out_ready  downstream accepts the output this cycle
//   out_bit    reduction result
//   out_mode   mode the result was computed with
// -----------------------------------------------------------------------------
module reduce_nway_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [1:0]       out_mode
);

  localparam int LAT = lat_of(WIDTH);
  localparam int PW  = 1 << LAT;  // padded width; 2 even for WIDTH=1

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = rst_n & en;

  logic [PW-1:0] pad_d;
  always_comb begin
    pad_d              = {PW{ident(in_mode)}};
    pad_d[WIDTH-1:0]   = in_data;
  end

  // All tree levels live in one flat vector: the padded word occupies the low
  // PW bits, and each level's output follows at offset 2*PW - (level width).
  logic [2*PW-2:0]     node;
  logic [LAT:0]        vld;
  logic [LAT:0][1:0]   md;

  assign node[PW-1:0] = pad_d;
  assign vld[0]       = in_valid & in_ready;
  assign md[0]        = in_mode;

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int IW      = PW >> k;
    localparam int IN_OFF  = 2*PW - 2*IW;
    localparam int OUT_OFF = 2*PW - IW;

    reduce_stage #(
      .IN_W (IW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .valid_i (vld[k]),
      .mode_i  (md[k]),
      .data_i  (node[IN_OFF +: IW]),
      .valid_o (vld[k+1]),
      .mode_o  (md[k+1]),
      .data_o  (node[OUT_OFF +: IW/2])
    );
  end

  assign out_valid = vld[LAT];
  assign out_mode  = md[LAT];
  assign out_bit   = (md[LAT] == MODE_NOR) ? ~node[2*PW-2] : node[2*PW-2];

endmodule
